// File: rtl/gpio_in_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gpio_in_pkg                                               |
// | Brief    : Shared types for the GPIO input capture path.             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package gpio_in_pkg;

    localparam int c_MAX_GPIO = 32;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } filt_state_e;

    typedef struct packed {
        logic [c_MAX_GPIO-1:0] d;
        logic                  de;
    } gpio_data_in_t;

endpackage
`default_nettype wire

// File: rtl/gpio_in_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gpio_in_filter                                            |
// | Brief    : One GPIO channel: pad synchroniser plus debounce filter.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module gpio_in_filter
    import gpio_in_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    input  logic filter_en_i,
    output logic filt_o
);

    localparam int                 c_CNT_W    = $clog2(FILTER_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    filt_state_e            r_state;
    filt_state_e            w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // In bypass the FSM tracks the synchronised level so enabling the filter never glitches.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!filter_en_i) begin
            w_state_nxt = w_sync ? ST_HI : ST_LO;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_LO: begin
                    if (w_sync) begin
                        w_state_nxt = WAIT_HI;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!w_sync) begin
                        w_state_nxt = ST_LO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ST_HI;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!w_sync) begin
                        w_state_nxt = WAIT_LO;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (w_sync) begin
                        w_state_nxt = ST_HI;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ST_LO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_LO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign filt_o = filter_en_i ? ((r_state == ST_HI) || (r_state == WAIT_LO)) : w_sync;

endmodule
`default_nettype wire

// File: rtl/gpio_in_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gpio_in_sampler                                           |
// | Brief    : GPIO input capture: sync/debounce, data_in d/de, edge IRQ.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module gpio_in_sampler
    import gpio_in_pkg::*;
#(
    parameter int NUM_GPIO      = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter bit DE_ALWAYS     = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_GPIO-1:0] cio_gpio_i,
    input  logic [NUM_GPIO-1:0] filter_en_i,
    input  logic [NUM_GPIO-1:0] intr_rise_en_i,
    input  logic [NUM_GPIO-1:0] intr_fall_en_i,
    input  logic [NUM_GPIO-1:0] intr_clr_i,
    output logic [NUM_GPIO-1:0] data_in_d_o,
    output logic                data_in_de_o,
    output logic [NUM_GPIO-1:0] intr_state_o,
    output logic                intr_o
);

    logic [NUM_GPIO-1:0] w_filt;
    logic [NUM_GPIO-1:0] r_d;
    logic [NUM_GPIO-1:0] r_d_q;
    logic                r_de;
    logic [NUM_GPIO-1:0] r_intr;
    logic [NUM_GPIO-1:0] w_rise;
    logic [NUM_GPIO-1:0] w_fall;
    logic [NUM_GPIO-1:0] w_set;
    gpio_data_in_t       w_data_in;

    generate
        for (genvar g = 0; g < NUM_GPIO; g++) begin : g_chan
            gpio_in_filter #(
                .SYNC_STAGES   (SYNC_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES)
            ) u_filter (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .pad_i       (cio_gpio_i[g]),
                .filter_en_i (filter_en_i[g]),
                .filt_o      (w_filt[g])
            );
        end
    endgenerate

    assign w_rise = r_d & ~r_d_q;
    assign w_fall = ~r_d & r_d_q;
    assign w_set  = (w_rise & intr_rise_en_i) | (w_fall & intr_fall_en_i);

    // de is registered alongside d so it marks the first cycle a new value is visible.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_d    <= '0;
            r_d_q  <= '0;
            r_de   <= 1'b0;
            r_intr <= '0;
        end else begin
            r_d    <= w_filt;
            r_d_q  <= r_d;
            r_de   <= DE_ALWAYS ? 1'b1 : |(w_filt ^ r_d);
            r_intr <= (r_intr & ~intr_clr_i) | w_set;
        end
    end

    always_comb begin
        w_data_in                   = '0;
        w_data_in.d[NUM_GPIO-1:0]   = r_d;
        w_data_in.de                = r_de;
    end

    assign data_in_d_o  = w_data_in.d[NUM_GPIO-1:0];
    assign data_in_de_o = w_data_in.de;
    assign intr_state_o = r_intr;
    assign intr_o       = |r_intr;

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_gpio_in_sampler                                        |
// | Brief    : Scoreboard bench for gpio_in_sampler against a level model|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_gpio_in_sampler;

    localparam int c_N  = 32;
    localparam int c_SS = 2;
    localparam int c_FC = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [c_N-1:0] cio_gpio;
    logic [c_N-1:0] filter_en;
    logic [c_N-1:0] rise_en;
    logic [c_N-1:0] fall_en;
    logic [c_N-1:0] intr_clr;
    logic [c_N-1:0] d_out;
    logic           de_out;
    logic [c_N-1:0] intr_state;
    logic           intr_out;

    always #5 clk = ~clk;

    gpio_in_sampler #(
        .NUM_GPIO      (c_N),
        .SYNC_STAGES   (c_SS),
        .FILTER_CYCLES (c_FC),
        .DE_ALWAYS     (1'b0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cio_gpio_i     (cio_gpio),
        .filter_en_i    (filter_en),
        .intr_rise_en_i (rise_en),
        .intr_fall_en_i (fall_en),
        .intr_clr_i     (intr_clr),
        .data_in_d_o    (d_out),
        .data_in_de_o   (de_out),
        .intr_state_o   (intr_state),
        .intr_o         (intr_out)
    );

    typedef struct {
        logic [c_N-1:0] d;
        logic           de;
        logic [c_N-1:0] intr;
    } exp_t;

    exp_t           exp_q[$];
    logic [c_N-1:0] chg_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;

    // stimulus levels held between steps
    logic [c_N-1:0] pad_v, fen_v, rise_v, fall_v, auto_clr;

    // reference model: pad history, sync history, filtered level, d history, irq state
    logic [c_N-1:0] m_pad_q[$];
    logic [c_N-1:0] m_s_q[$];
    logic [c_N-1:0] m_f, m_d, m_dq, m_intr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pad_q.delete();
        m_s_q.delete();
        for (int i = 0; i < c_SS - 1; i++) m_pad_q.push_back('0);
        for (int i = 0; i < c_FC; i++) m_s_q.push_back('0);
        m_f    = '0;
        m_d    = '0;
        m_dq   = '0;
        m_intr = '0;
    endfunction

    // One clock: drive inputs for the next rising edge and predict the outputs after it.
    task automatic step(input logic [c_N-1:0] clr);
        logic [c_N-1:0] clr_eff, s_k, all1, any1, d_new, intr_new;
        @(negedge clk);
        rst       = 1'b0;
        clr_eff   = clr | (auto_clr & (m_d ^ m_dq));
        cio_gpio  = pad_v;
        filter_en = fen_v;
        rise_en   = rise_v;
        fall_en   = fall_v;
        intr_clr  = clr_eff;

        d_new    = m_f;
        intr_new = (m_intr & ~clr_eff) | (rise_v & m_d & ~m_dq) | (fall_v & ~m_d & m_dq);
        exp_q.push_back('{d: d_new, de: (d_new != m_d), intr: intr_new});
        if (d_new != m_d) chg_q.push_back(d_new);

        m_pad_q.push_back(pad_v);
        s_k = m_pad_q[m_pad_q.size() - c_SS];
        if (m_pad_q.size() > c_SS) void'(m_pad_q.pop_front());

        // a filtered level follows sync only after FC consecutive equal samples
        all1 = '1;
        any1 = '0;
        foreach (m_s_q[i]) begin
            all1 &= m_s_q[i];
            any1 |= m_s_q[i];
        end
        m_f = (fen_v & ((m_f & any1) | all1)) | (~fen_v & s_k);
        m_s_q.push_back(s_k);
        void'(m_s_q.pop_front());

        m_dq   = m_d;
        m_d    = d_new;
        m_intr = intr_new;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step('0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_now_d", d_out, '0);
        check("reset_now_de", 32'(de_out), '0);
        check("reset_now_intr", intr_state, '0);
        check("reset_now_intr_o", 32'(intr_out), '0);
        model_reset();
        repeat (cycles) @(posedge clk);
    endtask

    // monitor: compare every post-edge output against the oldest prediction
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("reset_d", d_out, '0);
                check("reset_de", 32'(de_out), '0);
                check("reset_intr", intr_state, '0);
            end else if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL no_expectation: got d=%h with nothing predicted", d_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("d", d_out, mon_e.d);
                check("de", 32'(de_out), 32'(mon_e.de));
                check("intr_state", intr_state, mon_e.intr);
                check("intr_o", 32'(intr_out), 32'(|mon_e.intr));
                if (de_out) begin
                    if (chg_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL de_event: got de=1 d=%h expected no change", d_out);
                    end else begin
                        check("de_event_d", d_out, chg_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [c_N-1:0] flip;
        int             rate;
        rst       = 1'b1;
        cio_gpio  = '0;
        filter_en = '0;
        rise_en   = '0;
        fall_en   = '0;
        intr_clr  = '0;
        pad_v     = '0;
        fen_v     = 32'h0000_000A;
        rise_v    = '1;
        fall_v    = '1;
        auto_clr  = '0;
        model_reset();
        repeat (3) @(posedge clk);

        run(5);
        // bypass channel 0
        pad_v[0] = 1'b1; run(8);
        // filtered channel 1: short pulse rejected, long pulse passes
        pad_v[1] = 1'b1; run(10); pad_v[1] = 1'b0; run(25);
        pad_v[1] = 1'b1; run(20); pad_v[1] = 1'b0; run(25);
        // rise interrupt on 2 then write-1-to-clear
        pad_v[2] = 1'b1; run(6); step(32'h4); run(4);
        // clear coinciding with a fall edge on an already-set bit
        pad_v[2] = 1'b0; run(6); pad_v[2] = 1'b1; run(6);
        auto_clr = 32'h4; pad_v[2] = 1'b0; run(6);
        auto_clr = '0; step(32'h4); run(3);
        // reset while channel 3 is mid-count, pad stays high
        pad_v[3] = 1'b1; run(10);
        do_reset(3);
        run(c_FC + c_SS + 6);
        // enable filter on channel 4 while its pad is steady
        pad_v[4] = 1'b1; run(8); fen_v[4] = 1'b1; run(20);

        for (int ph = 0; ph < 3; ph++) begin
            run(c_FC + c_SS + 4);
            fen_v = $urandom();
            rate  = 8 + 8 * ph;
            for (int i = 0; i < 150; i++) begin
                flip = '0;
                for (int b = 0; b < c_N; b++)
                    if ($urandom_range(0, rate - 1) == 0) flip[b] = 1'b1;
                pad_v  = pad_v ^ flip;
                rise_v = $urandom();
                fall_v = $urandom();
                if (ph == 1 && i == 75) do_reset(int'($urandom_range(1, 3)));
                step(($urandom_range(0, 3) == 0) ? c_N'($urandom()) : '0);
            end
        end

        run(3);
        @(posedge clk);
        #2;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("chg_q_drained", 32'(chg_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
